// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, key-shift schedule and controller states.
package des_pkg;
  localparam int BLK_W  = 64;
  localparam int CD_W   = 56;
  localparam int SUB_W  = 48;
  localparam int HALF_W = 32;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Index 0 and 17 are padding so any 5-bit round index in use reads a defined entry.
  localparam logic [1:0] SHIFT [0:17] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                         2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int IPINV_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                  38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                  36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                  34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,
                                23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,
                                44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  // Entry n = row*16 + col, entry 0 in the leftmost nibble.
  localparam logic [0:63][3:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction
endpackage

// File: rtl/des_key_iter.sv
// Iterative key schedule: CD register, per-round rotation and PC-2 for the current subkey.
// Right-rotate (decrypt) path exists only with DES_DECRYPT_EN.
module des_key_iter import des_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [CD_W-1:0] i_cd,
  input  logic            i_step,
  input  logic [4:0]      i_rnd,
`ifdef DES_DECRYPT_EN
  input  logic            i_mode,
`endif
  output logic [SUB_W-1:0] o_k
);
  logic [CD_W-1:0] r_cd, w_cd_nxt, w_rotl;
  logic [1:0]      w_shl;

  assign w_shl  = SHIFT[i_rnd];
  assign w_rotl = {rotl28(r_cd[55:28], w_shl), rotl28(r_cd[27:0], w_shl)};

`ifdef DES_DECRYPT_EN
  logic [4:0]      w_didx;
  logic [1:0]      w_shr;
  logic [CD_W-1:0] w_rotr;
  // Decrypt walks the schedule backwards; round 1 uses CD as loaded (K16 == PC-2(C0D0)).
  assign w_didx   = (i_rnd >= 5'd2) ? 5'd18 - i_rnd : 5'd0;
  assign w_shr    = SHIFT[w_didx];
  assign w_rotr   = {rotr28(r_cd[55:28], w_shr), rotr28(r_cd[27:0], w_shr)};
  assign w_cd_nxt = !i_mode ? w_rotl : ((i_rnd == 5'd1) ? r_cd : w_rotr);
`else
  assign w_cd_nxt = w_rotl;
`endif

  pctwo u_pc2 (.i_cd(w_cd_nxt), .o_k(o_k));

  always_ff @(posedge clk) begin
    if (rst)         r_cd <= '0;
    else if (i_load) r_cd <= i_cd;
    else if (i_step) r_cd <= w_cd_nxt;
  end
endmodule

// File: rtl/des_prims.sv
// DES building blocks: IP, PC-1, PC-2, IP^-1 and the Feistel function f(R,K).
// Bit 63 of a 64-bit word is DES bit 1; tables hold 1-based DES bit numbers.
module dataip import des_pkg::*; (
  input  logic [BLK_W-1:0] i_d,
  output logic [BLK_W-1:0] o_d
);
  for (genvar i = 0; i < BLK_W; i++) begin : g_p
    assign o_d[BLK_W-1-i] = i_d[BLK_W-IP_T[i]];
  end
endmodule

module ipinverse import des_pkg::*; (
  input  logic [BLK_W-1:0] i_d,
  output logic [BLK_W-1:0] o_d
);
  for (genvar i = 0; i < BLK_W; i++) begin : g_p
    assign o_d[BLK_W-1-i] = i_d[BLK_W-IPINV_T[i]];
  end
endmodule

module pcone import des_pkg::*; (
  input  logic [BLK_W-1:0] i_key,
  output logic [CD_W-1:0]  o_cd
);
  logic w_unused_par;
  assign w_unused_par = ^i_key;  // parity bits are dropped by PC-1
  for (genvar i = 0; i < CD_W; i++) begin : g_p
    assign o_cd[CD_W-1-i] = i_key[BLK_W-PC1_T[i]];
  end
endmodule

module pctwo import des_pkg::*; (
  input  logic [CD_W-1:0]  i_cd,
  output logic [SUB_W-1:0] o_k
);
  logic w_unused_cd;
  assign w_unused_cd = ^i_cd;
  for (genvar i = 0; i < SUB_W; i++) begin : g_p
    assign o_k[SUB_W-1-i] = i_cd[CD_W-PC2_T[i]];
  end
endmodule

module fencode import des_pkg::*; (
  input  logic [HALF_W-1:0] i_r,
  input  logic [SUB_W-1:0]  i_k,
  output logic [HALF_W-1:0] o_f
);
  logic [SUB_W-1:0]  w_e, w_x;
  logic [HALF_W-1:0] w_s;
  for (genvar i = 0; i < SUB_W; i++) begin : g_e
    assign w_e[SUB_W-1-i] = i_r[HALF_W-E_T[i]];
  end
  assign w_x = w_e ^ i_k;
  for (genvar s = 0; s < 8; s++) begin : g_sb
    logic [5:0] w_six, w_n;
    assign w_six = w_x[47-6*s -: 6];
    assign w_n   = {w_six[5], w_six[0], w_six[4:1]};
    assign w_s[31-4*s -: 4] = SBOX[s][w_n];
  end
  for (genvar i = 0; i < HALF_W; i++) begin : g_p
    assign o_f[HALF_W-1-i] = w_s[HALF_W-P_T[i]];
  end
endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES engine: one shared round per clock, 16 rounds, valid/ready in and out.
// Optional decrypt mode (in_decrypt port) with DES_DECRYPT_EN.
module des_round_ctrl import des_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic [BLK_W-1:0] in_key,
`ifdef DES_DECRYPT_EN
  input  logic             in_decrypt,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
);
  state_t             r_state, w_state_nxt;
  logic [HALF_W-1:0]  r_l, r_r, w_f, w_r_nxt;
  logic [4:0]         r_rnd;
  logic               r_out_valid;
  logic [BLK_W-1:0]   r_out_data, w_ip, w_fin;
  logic [CD_W-1:0]    w_cd0;
  logic [SUB_W-1:0]   w_k;
  logic               w_acc;
`ifdef DES_DECRYPT_EN
  logic               r_mode;
`endif

  assign in_ready  = (r_state == IDLE) && !rst;
  assign w_acc     = in_valid && in_ready;
  assign w_r_nxt   = r_l ^ w_f;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != IDLE);

  dataip u_ip  (.i_d(in_data), .o_d(w_ip));
  pcone  u_pc1 (.i_key(in_key), .o_cd(w_cd0));

  des_key_iter u_key (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_acc),
    .i_cd   (w_cd0),
    .i_step (r_state == ROUND),
    .i_rnd  (r_rnd),
`ifdef DES_DECRYPT_EN
    .i_mode (r_mode),
`endif
    .o_k    (w_k)
  );

  fencode u_f (.i_r(r_r), .i_k(w_k), .o_f(w_f));
  // Final round output goes out with halves swapped: {R16, L16}.
  ipinverse u_ipi (.i_d({w_r_nxt, r_r}), .o_d(w_fin));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc)              w_state_nxt = ROUND;
      ROUND:   if (r_rnd == 5'd16)     w_state_nxt = DONE;
      DONE:    if (out_ready)          w_state_nxt = IDLE;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_l         <= '0;
      r_r         <= '0;
      r_rnd       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef DES_DECRYPT_EN
      r_mode      <= 1'b0;
`endif
    end else begin
      if (w_acc) begin
        {r_l, r_r} <= w_ip;
        r_rnd      <= 5'd1;
`ifdef DES_DECRYPT_EN
        r_mode     <= in_decrypt;
`endif
      end else if (r_state == ROUND) begin
        r_l   <= r_r;
        r_r   <= w_r_nxt;
        r_rnd <= r_rnd + 5'd1;
        if (r_rnd == 5'd16) begin
          r_out_data  <= w_fin;
          r_out_valid <= 1'b1;
        end
      end
      if (r_state == DONE && out_ready) r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_des_round_ctrl.sv
// Randomized self-checking bench for des_round_ctrl against a functional DES model.
module tb_des_round_ctrl;
  import des_pkg::*;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] in_data, in_key, out_data;
`ifdef DES_DECRYPT_EN
  logic        in_decrypt;
`endif
  int n_cmp = 0, n_bad = 0;

  des_round_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key),
`ifdef DES_DECRYPT_EN
    .in_decrypt(in_decrypt),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: whole-block DES, subkeys precomputed, decrypt = reversed subkeys
  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, p;
    logic [5:0]  six;
    int src, row, col;
    for (int g = 0; g < 8; g++)
      for (int j = 0; j < 6; j++) begin
        src = ((4*g + j - 1 + 32) % 32) + 1;
        e[47-(6*g+j)] = r[32-src];
      end
    e = e ^ k;
    for (int g = 0; g < 8; g++) begin
      six = e[47-6*g -: 6];
      row = 2*int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      s[31-4*g -: 4] = SBOX[g][row*16+col];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
    return p;
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] key, input bit dec);
    int          ipt [64];
    logic [47:0] ks [16];
    logic [63:0] ipd, pre, fin;
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [31:0] l, r, t;
    int          sh;
    for (int i = 0; i < 64; i++)
      ipt[i] = ((i/8 < 4) ? 58 + 2*(i/8) : 57 + 2*(i/8 - 4)) - 8*(i%8);
    for (int i = 0; i < 64; i++) ipd[63-i] = blk[64-ipt[i]];
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 1; n <= 16; n++) begin
      sh = (n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2;
      for (int q = 0; q < sh; q++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[n-1][47-i] = cd[56-PC2_T[i]];
    end
    l = ipd[63:32];
    r = ipd[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_ref(r, dec ? ks[15-i] : ks[i]);
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) fin[64-ipt[i]] = pre[63-i];
    return fin;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run(input logic [63:0] d, input logic [63:0] k, input bit dec,
                     input logic [63:0] exp, input int bp, input bit scr);
    int lat;
    in_data  = d;
    in_key   = k;
`ifdef DES_DECRYPT_EN
    in_decrypt = dec;
`endif
    in_valid  = 1'b1;
    out_ready = (bp == 0);
    chk("acc_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("busy_run", 64'(busy), 64'd1);
    chk("ready_low", 64'(in_ready), 64'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (scr) begin
        in_data = {$urandom(), $urandom()};
        in_key  = {$urandom(), $urandom()};
`ifdef DES_DECRYPT_EN
        in_decrypt = ~in_decrypt;
`endif
      end
      step();
      lat++;
    end
    chk("latency", 64'(lat), 64'd17);
    chk(dec ? "dec_data" : "enc_data", out_data, exp);
    for (int i = 0; i < bp; i++) begin
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", out_data, exp);
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_ready", 64'(in_ready), 64'd1);
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    bit seen, dec;
    logic [63:0] rd, rk;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
`ifdef DES_DECRYPT_EN
    in_decrypt = 1'b0;
`endif
    step(); step();
    chk("rst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready_rel", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // known-answer vectors
    run(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, 0, 1'b0);
    run(64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, 64'h0000000000000000, 0, 1'b1);
`ifdef DES_DECRYPT_EN
    run(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 64'h0123456789ABCDEF, 0, 1'b1);
`endif

    // backpressure, with the next block already waiting on in_valid
    in_data = 64'h0123456789ABCDEF; in_key = 64'h133457799BBCDFF1; in_valid = 1'b1; out_ready = 1'b0;
`ifdef DES_DECRYPT_EN
    in_decrypt = 1'b0;
`endif
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_latency", 64'(lat), 64'd17);
    in_valid = 1'b1;
    in_data  = 64'h8787878787878787;
    in_key   = 64'h0E329232EA6D0D73;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_data", out_data, 64'h85E813540F0AB405);
      chk("hold_ready", 64'(in_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    run(64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, 64'h0, 0, 1'b0);

    // reset during round 8 discards the block
    in_data = 64'h0123456789ABCDEF; in_key = 64'h133457799BBCDFF1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_lr", {dut.r_l, dut.r_r}, 64'd0);
    chk("mid_rst_rnd", 64'(dut.r_rnd), 64'd0);
    seen = 1'b0;
    repeat (25) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("no_output", 64'(seen), 64'd0);
    run(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, 0, 1'b0);

    // random blocks against the model
    for (int it = 0; it < 10; it++) begin
      rd = {$urandom(), $urandom()};
      rk = {$urandom(), $urandom()};
`ifdef DES_DECRYPT_EN
      dec = bit'($urandom_range(0, 1));
`else
      dec = 1'b0;
`endif
      run(rd, rk, dec, des_ref(rd, rk, dec), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
